// File: rtl/op_scheduler_if.sv
// CSR-side descriptor push and datapath-side active-op bus for op_scheduler.
interface op_scheduler_if;
  logic        csr_en;
  logic        csr_ope;
  logic [11:0] csr_opleft, csr_opright, csr_optop, csr_opbottom;
  logic [7:0]  csr_opparam, csr_oplength, csr_opcmd;
  logic        frame_start;
  logic [11:0] op_left, op_right, op_top, op_bottom;
  logic [7:0]  op_param, op_cmd;
  logic        op_active, op_start, op_done, op_busy, op_queue, op_overflow;

  modport slave (
    input  csr_en, csr_ope, csr_opleft, csr_opright, csr_optop, csr_opbottom,
           csr_opparam, csr_oplength, csr_opcmd, frame_start,
    output op_left, op_right, op_top, op_bottom, op_param, op_cmd,
           op_active, op_start, op_done, op_busy, op_queue, op_overflow
  );

  modport master (
    output csr_en, csr_ope, csr_opleft, csr_opright, csr_optop, csr_opbottom,
           csr_opparam, csr_oplength, csr_opcmd, frame_start,
    input  op_left, op_right, op_top, op_bottom, op_param, op_cmd,
           op_active, op_start, op_done, op_busy, op_queue, op_overflow
  );
endinterface

// File: rtl/op_scheduler.sv
// Frame-aligned op descriptor queue and launcher.
// Optional OPSCHED_FLUSH_CMD_EN: a push of cmd 8'hFF flushes the queue and aborts the running op.
module op_scheduler #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  op_scheduler_if.slave bus
);
  typedef struct packed {
    logic [11:0] left, right, top, bottom;
    logic [7:0]  param, length, cmd;
  } desc_t;

  typedef enum logic [1:0] {IDLE, PEND, RUN} state_t;

  state_t     state;
  desc_t      mem [DEPTH];
  desc_t      head, wdesc;
  logic [AW:0] wr, rd, cnt, cnt_nxt;
  logic [7:0] frames_left;
  logic       full, empty, flush, last, pop, push_ok;

  always_comb begin
    cnt     = wr - rd;
    full    = (cnt == (AW+1)'(DEPTH));
    empty   = (cnt == '0);
    flush   = !bus.csr_en;
`ifdef OPSCHED_FLUSH_CMD_EN
    flush   = flush | (bus.csr_ope && bus.csr_opcmd == 8'hFF);
`endif
    last    = (state == RUN) && bus.frame_start && (frames_left == 8'd1);
    pop     = !flush && bus.frame_start && !empty && ((state == PEND) || last);
    // A pop in the same cycle frees the slot the push needs
    push_ok = !flush && bus.csr_ope && (!full || pop);
    cnt_nxt = cnt + (AW+1)'(push_ok) - (AW+1)'(pop);
    head    = mem[rd[AW-1:0]];
    wdesc   = '{bus.csr_opleft, bus.csr_opright, bus.csr_optop, bus.csr_opbottom,
                bus.csr_opparam, bus.csr_oplength, bus.csr_opcmd};
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr[AW-1:0]] <= wdesc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr            <= '0;
      rd            <= '0;
      frames_left   <= '0;
      bus.op_left   <= '0;
      bus.op_right  <= '0;
      bus.op_top    <= '0;
      bus.op_bottom <= '0;
      bus.op_param  <= '0;
      bus.op_cmd    <= '0;
      bus.op_active <= 1'b0;
      bus.op_start  <= 1'b0;
      bus.op_done   <= 1'b0;
      bus.op_busy   <= 1'b0;
      bus.op_queue  <= 1'b0;
      bus.op_overflow <= 1'b0;
    end else begin
      bus.op_start <= 1'b0;
      bus.op_done  <= 1'b0;
      if (flush) begin
        rd            <= wr;
        state         <= IDLE;
        frames_left   <= '0;
        bus.op_active <= 1'b0;
        bus.op_busy   <= 1'b0;
        bus.op_queue  <= 1'b0;
      end else begin
        if (push_ok) wr <= wr + 1'b1;
        if (pop)     rd <= rd + 1'b1;
        if (bus.csr_ope && !push_ok) bus.op_overflow <= 1'b1;
        bus.op_queue <= (cnt_nxt == (AW+1)'(DEPTH));
        if (last) bus.op_done <= 1'b1;
        if (pop) begin
          bus.op_left   <= head.left;
          bus.op_right  <= head.right;
          bus.op_top    <= head.top;
          bus.op_bottom <= head.bottom;
          bus.op_param  <= head.param;
          bus.op_cmd    <= head.cmd;
          bus.op_start  <= 1'b1;
          bus.op_active <= 1'b1;
          bus.op_busy   <= 1'b1;
          frames_left   <= (head.length == 8'd0) ? 8'd1 : head.length;
          state         <= RUN;
        end else begin
          case (state)
            IDLE: if (push_ok) begin
              state       <= PEND;
              bus.op_busy <= 1'b1;
            end
            RUN: if (bus.frame_start) begin
              if (last) begin
                // Queue drained; a push landing this cycle goes straight to PEND
                bus.op_active <= 1'b0;
                frames_left   <= '0;
                state         <= push_ok ? PEND : IDLE;
                bus.op_busy   <= push_ok;
              end else begin
                frames_left <= frames_left - 8'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_op_scheduler.sv
// Scoreboarded random/directed bench for op_scheduler against a queue-based op model.
module tb_op_scheduler;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [11:0] l, r, t, b;
    logic [7:0]  p, len, cmd;
  } desc_t;
  typedef struct {
    desc_t d;
    int    cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  op_scheduler_if bus();

  op_scheduler #(.DEPTH(DEPTH), .AW(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int    tests = 0, fails = 0;
  int    cyc = 0;
  int    start_seen = 0, done_seen = 0;
  int    m_launches = 0, m_dones = 0;
  exp_t  exp_q[$];
  desc_t mq[$];
  bit    m_run, m_ovf, m_done;
  int    m_left;
  desc_t m_cur;
  desc_t d0 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] ofields();
    return {bus.op_left, bus.op_right, bus.op_top, bus.op_bottom, bus.op_param, bus.op_cmd};
  endfunction

  function automatic logic [63:0] dfields(desc_t d);
    return {d.l, d.r, d.t, d.b, d.p, d.cmd};
  endfunction

  function automatic desc_t rnd_desc(int len);
    desc_t d;
    d.l = 12'($urandom); d.r = 12'($urandom); d.t = 12'($urandom); d.b = 12'($urandom);
    d.p = 8'($urandom); d.len = 8'(len);
    d.cmd = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
    return d;
  endfunction

  // Monitor: every op_start must match the next scheduled launch, in order and on time
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (bus.op_done === 1'b1) done_seen++;
      if (bus.op_start === 1'b1) begin
        start_seen++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_op_start at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("start_cycle", 64'(cyc), 64'(e.cyc));
          chk("start_fields", ofields(), dfields(e.d));
        end
      end
    end
  end

  task automatic launch();
    desc_t nd;
    nd = mq.pop_front();
    m_cur  = nd;
    m_run  = 1'b1;
    m_left = (nd.len == 0) ? 1 : int'(nd.len);
    m_launches++;
    exp_q.push_back('{d: nd, cyc: cyc + 1});
  endtask

  task automatic step(bit en, bit ope, bit fs, desc_t d);
    bit flush;
    bus.csr_en = en; bus.csr_ope = ope; bus.frame_start = fs;
    bus.csr_opleft = d.l; bus.csr_opright = d.r; bus.csr_optop = d.t; bus.csr_opbottom = d.b;
    bus.csr_opparam = d.p; bus.csr_oplength = d.len; bus.csr_opcmd = d.cmd;
    flush = !en;
`ifdef OPSCHED_FLUSH_CMD_EN
    flush = flush | (ope && d.cmd == 8'hFF);
`endif
    m_done = 1'b0;
    if (flush) begin
      mq.delete();
      m_run = 1'b0; m_left = 0;
    end else begin
      if (fs && m_run) begin
        if (m_left == 1) begin
          m_done = 1'b1; m_dones++;
          if (mq.size() > 0) launch();
          else begin m_run = 1'b0; m_left = 0; end
        end else m_left--;
      end else if (fs && mq.size() > 0) launch();
      if (ope) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk("op_done", 64'(bus.op_done), 64'(m_done));
    chk("op_active", 64'(bus.op_active), 64'(m_run));
    chk("op_busy", 64'(bus.op_busy), 64'(m_run || mq.size() > 0));
    chk("op_queue", 64'(bus.op_queue), 64'(mq.size() == DEPTH));
    chk("op_overflow", 64'(bus.op_overflow), 64'(m_ovf));
    chk("op_fields_hold", ofields(), dfields(m_cur));
  endtask

  task automatic idle(int n);
    repeat (n) step(1, 0, 0, d0);
  endtask

  task automatic frames(int n, int gap);
    repeat (n) begin step(1, 0, 1, d0); idle(gap); end
  endtask

  task automatic push(int len);
    desc_t d;
    d = rnd_desc(len);
    d.cmd = 8'($urandom_range(0, 254));
    step(1, 1, 0, d);
  endtask

  task automatic model_reset();
    mq.delete(); exp_q.delete();
    m_run = 1'b0; m_ovf = 1'b0; m_done = 1'b0; m_left = 0; m_cur = '0;
  endtask

  initial begin
    desc_t ff;
    model_reset();
    bus.csr_en = 1'b0; bus.csr_ope = 1'b0; bus.frame_start = 1'b0;
    bus.csr_opleft = '0; bus.csr_opright = '0; bus.csr_optop = '0; bus.csr_opbottom = '0;
    bus.csr_opparam = '0; bus.csr_oplength = '0; bus.csr_opcmd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_fields", ofields(), 64'h0);
    chk("reset_status", 64'({bus.op_active, bus.op_start, bus.op_done, bus.op_busy,
                            bus.op_queue, bus.op_overflow}), 64'h0);
    rst_n = 1'b1;
    idle(2);

    // single op, length 3, four frames
    push(3); idle(2); frames(4, 3);
    // back-to-back len 1 then len 2
    push(1); push(2); idle(1); frames(4, 2);
    // overfill with no frames, then drain
    push(1); push(0); push(2); push(1); push(1); idle(2);
    frames(8, 1);
    // zero length op
    push(0); frames(3, 2);
    // push coinciding with frame_start while IDLE
    step(1, 1, 1, rnd_desc(1)); frames(3, 1);
    // disable mid-run with two queued
    push(4); push(2); push(2); frames(2, 1);
    step(0, 0, 0, d0); idle(2); frames(3, 1);
    // 3 queued then cmd FF
    push(1); push(1); push(1);
    ff = rnd_desc(1); ff.cmd = 8'hFF;
    step(1, 1, 0, ff); idle(2); frames(8, 1);
    // async reset mid-run
    push(5); frames(2, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_fields", ofields(), 64'h0);
    chk("async_reset_status", 64'({bus.op_active, bus.op_start, bus.op_done, bus.op_busy,
                                  bus.op_queue, bus.op_overflow}), 64'h0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), rnd_desc($urandom_range(0, 4)));
    end
    step(0, 0, 0, d0); idle(4);

    chk("launch_count", 64'(start_seen), 64'(m_launches));
    chk("done_count", 64'(done_seen), 64'(m_dones));
    chk("pending_starts", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
